// File: rtl/uart_frame_parser_if.sv
// Byte-stream bus between the UART receiver, the frame parser and the command layer.
// The parser sits on the slave side; the driver/consumer pair uses the master side.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [7:0]    pi_data;
  logic          pi_flag;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [LW-1:0] out_len;
  logic          frame_ok;
  logic          frame_err;
  logic [1:0]    err_code;

  modport master (
    output pi_data, pi_flag, out_ready,
    input  out_data, out_valid, out_last, out_len, frame_ok, frame_err, err_code
  );

  modport slave (
    input  pi_data, pi_flag, out_ready,
    output out_data, out_valid, out_last, out_len, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Header hunt, length-prefixed payload capture and additive checksum check on a UART
// byte stream; only good frames are replayed as a valid/ready byte stream.
module uart_frame_parser #(
  parameter int         clk_frequence  = 5_000_000,
  parameter int         baud_rate      = 9600,
  parameter logic [7:0] HEADER0        = 8'h55,
  parameter logic [7:0] HEADER1        = 8'hAA,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 20 * clk_frequence / baud_rate
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_frame_parser_if.slave  bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // The counter reads 0 in the first idle cycle after a strobe, so firing at
  // TIMEOUT_CYCLES-2 puts frame_err exactly TIMEOUT_CYCLES cycles after that strobe.
  localparam logic [TW-1:0] TMO_FIRE  = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, HDR1, LEN, PAYLOAD, CSUM, SEND} state_t;

  state_t        state;
  logic [7:0]    buffer [MAX_LEN];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] len;
  logic [LW-1:0] len_m1;
  logic [7:0]    acc;
  logic [TW-1:0] tmo_cnt;
  logic          timed;
  logic          buf_we;
  logic          xfer;

  assign len_m1 = len - LW'(1);
  assign timed  = (state == HDR1) || (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign buf_we = (state == PAYLOAD) && bus.pi_flag;
  assign xfer   = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buffer[wr_ptr] <= bus.pi_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      len           <= '0;
      acc           <= '0;
      tmo_cnt       <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_len   <= '0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_code  <= 2'd0;
    end else begin
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;

      if (timed && !bus.pi_flag) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      case (state)
        IDLE: begin
          if (bus.pi_flag && bus.pi_data == HEADER0) begin
            state <= HDR1;
          end
        end

        HDR1: begin
          if (bus.pi_flag) begin
            if (bus.pi_data == HEADER1) begin
              state <= LEN;
            end else if (bus.pi_data != HEADER0) begin
              state <= IDLE;
            end
          end
        end

        LEN: begin
          if (bus.pi_flag) begin
            if (bus.pi_data == 8'd0 || bus.pi_data > MAX_LEN_B) begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= 2'd1;
              state         <= IDLE;
            end else begin
              len    <= LW'(bus.pi_data);
              acc    <= bus.pi_data;
              wr_ptr <= '0;
              state  <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (bus.pi_flag) begin
            acc    <= acc + bus.pi_data;
            wr_ptr <= wr_ptr + PW'(1);
            if (LW'(wr_ptr) == len_m1) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (bus.pi_flag) begin
            if (bus.pi_data == acc) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= buffer[0];
              bus.out_last  <= (len == LW'(1));
              bus.out_len   <= len;
              bus.frame_ok  <= 1'b1;
              rd_ptr        <= PW'(1);
              state         <= SEND;
            end else begin
              bus.frame_err <= 1'b1;
              bus.err_code  <= 2'd2;
              state         <= IDLE;
            end
          end
        end

        SEND: begin
          // Bytes arriving while the buffer is being replayed cannot be stored.
          if (bus.pi_flag) begin
            bus.frame_err <= 1'b1;
            bus.err_code  <= 2'd0;
          end
          if (xfer) begin
            if (bus.out_last) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              state         <= IDLE;
            end else begin
              bus.out_data <= buffer[rd_ptr];
              bus.out_last <= (LW'(rd_ptr) == len_m1);
              rd_ptr       <= rd_ptr + PW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (timed && !bus.pi_flag && tmo_cnt == TMO_FIRE) begin
        bus.frame_err <= 1'b1;
        bus.err_code  <= 2'd3;
        state         <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed and randomized frames against a frame-level model of the parser;
// a monitor captures the output stream, pulses and the back-pressure hold rule.
module tb_uart_frame_parser;

  localparam int MAX_LEN        = 16;
  localparam int TIMEOUT_CYCLES = 20 * 5_000_000 / 9600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_parser #(.MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         ok_cnt = 0;
  int         ready_mode = 0;
  int         last_good_len = 0;
  logic [8:0] got_q [$];
  int         err_q [$];
  logic [7:0] exp_q [$];
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic       pl = 1'b0;
  logic [7:0] pd = 8'd0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer: 0 always ready, 1 toggling, 2 random, 3 stalled.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Output capture plus the rule that a stalled byte must not change.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check_val("hold_valid", 32'(bus.out_valid), 1);
          check_val("hold_data", 32'(bus.out_data), 32'(pd));
          check_val("hold_last", 32'(bus.out_last), 32'(pl));
        end
        if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
        if (bus.frame_ok) ok_cnt++;
        if (bus.frame_err) err_q.push_back(int'(bus.err_code));
        pv = bus.out_valid;
        pr = bus.out_ready;
        pd = bus.out_data;
        pl = bus.out_last;
      end
    end
  end

  task automatic clear_capture();
    got_q.delete();
    err_q.delete();
    exp_q.delete();
    ok_cnt = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    bus.pi_data = b;
    bus.pi_flag = 1'b1;
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] bytes [$], input int max_gap);
    foreach (bytes[i]) applyStimulus(bytes[i], $urandom_range(0, max_gap));
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] frame_csum(input int n, input logic [7:0] p [$]);
    int s = n;
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  task automatic checkOutput(input string tag, input int exp_ok, input int exp_err, input int exp_len);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, "_data"}, 32'(got_q[i][7:0]), 32'(exp_q[i]));
      check_val({tag, "_last"}, 32'(got_q[i][8]), (i == exp_q.size() - 1) ? 1 : 0);
    end
    check_val({tag, "_ok"}, 32'(ok_cnt), 32'(exp_ok));
    check_val({tag, "_errs"}, 32'(err_q.size()), (exp_err < 0) ? 0 : 1);
    if (exp_err >= 0 && err_q.size() > 0) check_val({tag, "_code"}, 32'(err_q[0]), 32'(exp_err));
    check_val({tag, "_len"}, 32'(bus.out_len), 32'(exp_len));
  endtask

  initial begin
    logic [7:0] frame [$];
    logic [7:0] pay [$];
    logic [7:0] b;
    int         n;
    int         kind;
    int         cycles;
    bit         seen;

    bus.pi_data = 8'd0;
    bus.pi_flag = 1'b0;
    ready_mode  = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_data", 32'(bus.out_data), 0);
    check_val("rst_out_valid", 32'(bus.out_valid), 0);
    check_val("rst_out_last", 32'(bus.out_last), 0);
    check_val("rst_out_len", 32'(bus.out_len), 0);
    check_val("rst_frame_ok", 32'(bus.frame_ok), 0);
    check_val("rst_frame_err", 32'(bus.frame_err), 0);
    check_val("rst_err_code", 32'(bus.err_code), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] good frame");
    clear_capture();
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_frame('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33}, 1);
    applyStimulus(8'h69, 0);
    @(negedge clk);
    check_val("latency_valid", 32'(bus.out_valid), 1);
    check_val("latency_ok", 32'(bus.frame_ok), 1);
    wait_drain(50);
    checkOutput("good", 1, -1, 3);
    last_good_len = 3;

    $display("[TB] bad checksum");
    clear_capture();
    send_frame('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}, 1);
    wait_drain(10);
    checkOutput("bad_csum", 0, 2, 3);

    $display("[TB] length limits");
    clear_capture();
    send_frame('{8'h55, 8'hAA, 8'h00}, 0);
    wait_drain(5);
    checkOutput("len_zero", 0, 1, 3);
    clear_capture();
    send_frame('{8'h55, 8'hAA, 8'h11}, 0);
    wait_drain(5);
    checkOutput("len_over", 0, 1, 3);
    clear_capture();
    ready_mode = 2;
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'($urandom_range(0, 255)));
    frame = '{8'h55, 8'hAA, 8'h10};
    foreach (pay[i]) frame.push_back(pay[i]);
    frame.push_back(frame_csum(16, pay));
    exp_q = pay;
    send_frame(frame, 1);
    wait_drain(300);
    checkOutput("len_max", 1, -1, 16);
    last_good_len = 16;

    $display("[TB] timeout");
    ready_mode = 0;
    clear_capture();
    send_frame('{8'h55, 8'hAA, 8'h02}, 0);
    applyStimulus(8'h11, 0);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < TIMEOUT_CYCLES + 20) begin
      @(negedge clk);
      cycles++;
      if (bus.frame_err) seen = 1'b1;
    end
    check_val("timeout_cycles", 32'(cycles), 32'(TIMEOUT_CYCLES));
    wait_drain(5);
    checkOutput("timeout", 0, 3, 16);
    clear_capture();
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_frame('{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0);
    wait_drain(50);
    checkOutput("after_timeout", 1, -1, 3);

    $display("[TB] resync with back-pressure");
    ready_mode = 1;
    clear_capture();
    exp_q = '{8'h7E};
    send_frame('{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F}, 0);
    wait_drain(50);
    checkOutput("resync", 1, -1, 1);

    $display("[TB] overrun");
    ready_mode = 3;
    clear_capture();
    exp_q = '{8'hA1, 8'hB2};
    send_frame('{8'h55, 8'hAA, 8'h02, 8'hA1, 8'hB2, 8'h55}, 0);
    repeat (3) @(posedge clk);
    applyStimulus(8'h55, 2);
    ready_mode = 0;
    wait_drain(50);
    checkOutput("overrun", 1, 0, 2);

    $display("[TB] reset during SEND");
    ready_mode = 3;
    clear_capture();
    send_frame('{8'h55, 8'hAA, 8'h02, 8'hC3, 8'h3C, 8'h01}, 0);
    repeat (2) @(posedge clk);
    #1;
    clear_capture();
    rst_n = 1'b0;
    @(negedge clk);
    check_val("abort_valid", 32'(bus.out_valid), 0);
    check_val("abort_len", 32'(bus.out_len), 0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    ready_mode = 0;
    wait_drain(10);
    checkOutput("abort", 0, -1, 0);
    last_good_len = 0;

    $display("[TB] random frames");
    for (int f = 0; f < 25; f++) begin
      clear_capture();
      ready_mode = $urandom_range(0, 2);
      kind       = $urandom_range(0, 9);
      frame.delete();
      pay.delete();
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        do b = 8'($urandom_range(0, 255)); while (b == 8'h55);
        frame.push_back(b);
      end
      frame.push_back(8'h55);
      frame.push_back(8'hAA);
      if (kind >= 8) begin
        n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        frame.push_back(8'(n));
        send_frame(frame, 2);
        wait_drain(10);
        checkOutput("rand_len", 0, 1, last_good_len);
      end else begin
        n = $urandom_range(1, MAX_LEN);
        frame.push_back(8'(n));
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
        foreach (pay[i]) frame.push_back(pay[i]);
        if (kind < 6) begin
          frame.push_back(frame_csum(n, pay));
          exp_q = pay;
          send_frame(frame, 2);
          wait_drain(40 + 10 * n);
          checkOutput("rand_good", 1, -1, n);
          last_good_len = n;
        end else begin
          frame.push_back(frame_csum(n, pay) + 8'($urandom_range(1, 255)));
          send_frame(frame, 2);
          wait_drain(10);
          checkOutput("rand_csum", 0, 2, last_good_len);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
